piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in, serial-out transmitter: the sending end of the bit-serial link
//  whose receiver shifts each bit into the LSB of a DATA_WIDTH-bit word.
//  Accepts one DATA_WIDTH-bit word over a valid/ready handshake and emits it
//  one bit per clock, MSB first. A receiving SIPO that samples on dout_valid
//  therefore reassembles the original word.
//  Supports back-to-back words with no idle cycle between them.
// PARAMETERS
//  DATA_WIDTH  16  Word width in bits; legal range >= 1.
// PORTS
//  clk         in   1           Single clock; all state updates on posedge clk.
//  reset       in   1           Asynchronous, active-high reset.
//  din         in   DATA_WIDTH  Parallel word; sampled only on accept.
//  din_valid   in   1           Producer has a word on din.
//  din_ready   out  1           Block can take a word this cycle.
//  dout        out  1           Serial data bit.
//  dout_valid  out  1           dout carries a word bit this cycle.
//  dout_last   out  1           dout is bit 0, the final bit of the current word.
// BEHAVIOUR
//  Reset values (async, held while reset=1):
//   dout=0, dout_valid=0, dout_last=0, state=IDLE, shift reg=0, count=0.
//   din_ready=0 while reset is high.
//  Accept: accept = din_valid & din_ready, evaluated at the clock edge.
//   On accept, din is captured into the shift register and count loads DATA_WIDTH-1.
//   Words offered while din_ready=0 are ignored and not captured.
//   Changes on din after accept have no effect on the word in flight.
//  State machine:
//   IDLE  - din_ready=1, dout_valid=0. Accept -> SHIFT.
//   SHIFT - dout_valid=1 and dout = shift_reg[DATA_WIDTH-1].
//           Each cycle: shift left by 1 (zero fill) and decrement count.
//           When count==0: dout_last=1 and din_ready=1.
//             If accept in that cycle: reload, stay in SHIFT (no bubble).
//             Otherwise -> IDLE.
//  Outputs: dout, dout_valid and dout_last are registered (no combinational
//   path from din/din_valid). din_ready is combinational from state/count only.
//  Latency:
//   First bit appears the cycle after accept.
//   A word occupies exactly DATA_WIDTH consecutive dout_valid cycles.
//   Sustained throughput is 1 bit/cycle with continuous din_valid.
//  Idle outputs: whenever dout_valid=0, both dout and dout_last are 0.
//  Width rules:
//   count is max(1,$clog2(DATA_WIDTH)) bits wide.
//   DATA_WIDTH=1: every valid bit has dout_last=1 and din_ready stays 1 out of reset.
//  Reset mid-word: remaining bits are discarded and no partial tail is emitted.
//   After release, the block sits in IDLE awaiting a new accept.
// TESTING
//  W=6, accept din=6'b101100 in IDLE:
//   -> next 6 cycles dout=1,0,1,1,0,0; dout_valid=1; dout_last only on the 6th;
//   -> then dout_valid=0.
//  W=6, din_valid held high with words 6'b111000 then 6'b010101:
//   -> 12 contiguous valid cycles; din_ready=1 only on the cycle with dout_last.
//  Loopback to a 6-bit receiving SIPO clocked on dout_valid, random words:
//   -> receiver holds each sent word the cycle after its dout_last.
//  Assert reset after the 3rd bit of 6'b110011:
//   -> all outputs 0 immediately (async); no further bits;
//   -> after release, din_ready=1 and the next word serializes correctly.
//  din_valid=1 while din_ready=0 (mid-word) with din changing every cycle:
//   -> word in flight unchanged; new word accepted only at dout_last.
//  DATA_WIDTH=1, din toggling with din_valid=1:
//   -> dout follows din one cycle later; dout_valid=dout_last=1 every cycle.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. Takes one word over a valid/ready
// handshake and emits it MSB first, one bit per clock, with optional
// back-to-back reload on the final bit so the serial stream has no bubbles.
module piso_serializer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  dout_last
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_last_q, dout_last_d;
    logic                  accept;

    // Ready in idle or on the final bit of a word; forced low while in reset.
    assign din_ready = ~reset & ((state_q == StIdle) | (count_q == '0));
    assign accept    = din_valid & din_ready;

    // Next-state logic: load on accept, otherwise shift out and count down.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    shift_d = din;
                    count_d = CntLoad;
                end
            end
            StShift: begin
                if (accept) begin
                    // Reload on the last bit keeps the stream contiguous.
                    shift_d = din;
                    count_d = CntLoad;
                end else begin
                    shift_d = shift_q << 1;
                    if (count_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        count_d = count_q - CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next values derive from next state so outputs come straight from flops.
    always_comb begin
        dout_valid_d = (state_d == StShift);
        dout_d       = dout_valid_d & shift_d[DATA_WIDTH-1];
        dout_last_d  = dout_valid_d & (count_d == '0);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            count_q      <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer at DATA_WIDTH=6 and DATA_WIDTH=1.
module tb_piso_serializer;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid, din_ready, dout, dout_valid, dout_last;
    logic [0:0]   d1_din;
    logic         d1_valid, d1_ready, d1_dout, d1_dout_valid, d1_dout_last;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0]   exp_q[$];   // {bit, last}
    logic [W-1:0] word_q[$];
    logic [W-1:0] rx;

    always #5 clk = ~clk;

    // Receiving SIPO: shifts each valid bit into the LSB.
    always @(posedge clk) if (dout_valid) rx <= {rx[W-2:0], dout};

    piso_serializer #(.DATA_WIDTH(W)) dut6 (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
    );

    piso_serializer #(.DATA_WIDTH(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .din        (d1_din),
        .din_valid  (d1_valid),
        .din_ready  (d1_ready),
        .dout       (d1_dout),
        .dout_valid (d1_dout_valid),
        .dout_last  (d1_dout_last)
    );

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back({w[i], (i == 0)});
    endtask

    task automatic test_reset();
        reset = 1'b1; din = '0; din_valid = 1'b0; d1_din = '0; d1_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({din_ready, dout, dout_valid, dout_last} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_w6: got %b want 0000", {din_ready, dout, dout_valid, dout_last});
        end
        vectors++;
        if ({d1_ready, d1_dout, d1_dout_valid, d1_dout_last} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_w1: got %b want 0000",
                     {d1_ready, d1_dout, d1_dout_valid, d1_dout_last});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({din_ready, d1_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 11", {din_ready, d1_ready});
        end
    endtask

    task automatic test_single_word(input logic [W-1:0] w, input string nm);
        logic [1:0] e;
        din = w; din_valid = 1'b1; push_word(w);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            din_valid = 1'b0;
            vectors++;
            if (dout_valid !== (c < 6)) begin
                miscompares++;
                $display("FAIL %s valid c=%0d: got %b want %b", nm, c, dout_valid, (c < 6));
            end
            if (dout_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_bit c=%0d: got bit, want none", nm, c);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout, dout_last} !== e) begin
                        miscompares++;
                        $display("FAIL %s bit c=%0d: got %b want %b", nm, c, {dout, dout_last}, e);
                    end
                end
            end else begin
                vectors++;
                if ({dout, dout_last} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL %s idle c=%0d: got %b want 00", nm, c, {dout, dout_last});
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s leftover: got %0d want 0", nm, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        @(negedge clk);
        din = 6'b111000; din_valid = 1'b1; push_word(din);
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            vectors++;
            if (dout_valid !== (c < 12)) begin
                miscompares++;
                $display("FAIL b2b valid c=%0d: got %b want %b", c, dout_valid, (c < 12));
            end
            if (dout_valid === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({dout, dout_last} !== e) begin
                    miscompares++;
                    $display("FAIL b2b bit c=%0d: got %b want %b", c, {dout, dout_last}, e);
                end
                vectors++;
                if (din_ready !== e[0]) begin
                    miscompares++;
                    $display("FAIL b2b ready c=%0d: got %b want %b", c, din_ready, e[0]);
                end
            end
            if (c == 0) begin
                din = 6'b010101; push_word(din);
            end
            if (c == 11) din_valid = 1'b0;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b leftover: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_loopback();
        int           sent = 0;
        logic         prev_last = 1'b0;
        logic [W-1:0] w;
        for (int c = 0; c < 8 * W + 4; c++) begin
            @(negedge clk);
            if (prev_last) begin
                vectors++;
                if (word_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL loopback extra_word c=%0d: got %b want none", c, rx);
                end else begin
                    w = word_q.pop_front();
                    if (rx !== w) begin
                        miscompares++;
                        $display("FAIL loopback word c=%0d: got %b want %b", c, rx, w);
                    end
                end
            end
            prev_last = dout_valid & dout_last;
            if (din_ready) begin
                if (sent < 8) begin
                    din = W'($urandom); din_valid = 1'b1;
                    word_q.push_back(din);
                    sent++;
                end else begin
                    din_valid = 1'b0;
                end
            end
        end
        vectors++;
        if (word_q.size() != 0) begin
            miscompares++;
            $display("FAIL loopback leftover: got %0d want 0", word_q.size());
        end
    endtask

    task automatic test_reset_mid_word();
        logic [1:0] e;
        @(negedge clk);
        din = 6'b110011; din_valid = 1'b1; push_word(din);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            din_valid = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({dout_valid, dout, dout_last} !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL midrst bit c=%0d: got %b want %b", c,
                         {dout_valid, dout, dout_last}, {1'b1, e});
            end
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({din_ready, dout, dout_valid, dout_last} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst async: got %b want 0000", {din_ready, dout, dout_valid, dout_last});
        end
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if ({dout, dout_valid, dout_last} !== 3'b000) begin
                miscompares++;
                $display("FAIL midrst held: got %b want 000", {dout, dout_valid, dout_last});
            end
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst ready: got %b want 1", din_ready);
        end
        test_single_word(6'b100110, "after_rst");
    endtask

    task automatic test_din_change();
        logic [1:0] e;
        @(negedge clk);
        din = 6'b011010; din_valid = 1'b1; push_word(din);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            vectors++;
            if ({dout_valid, din_ready} !== {(c < 12), (c == 5 || c >= 11)}) begin
                miscompares++;
                $display("FAIL dinchg ctl c=%0d: got %b want %b", c, {dout_valid, din_ready},
                         {(c < 12), (c == 5 || c >= 11)});
            end
            if (dout_valid === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({dout, dout_last} !== e) begin
                    miscompares++;
                    $display("FAIL dinchg bit c=%0d: got %b want %b", c, {dout, dout_last}, e);
                end
            end
            if (c == 5) begin
                din = 6'b101001; din_valid = 1'b1; push_word(din);
            end else begin
                din = W'($urandom); din_valid = (c < 11);
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL dinchg leftover: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_width1();
        logic [7:0] pat = 8'b1011_0010;
        logic [1:0] e;
        @(negedge clk);
        d1_din = pat[0]; d1_valid = 1'b1; exp_q.push_back({pat[0], 1'b1});
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            vectors++;
            if (c < 8) begin
                e = exp_q.pop_front();
                if ({d1_dout_valid, d1_ready, d1_dout, d1_dout_last} !== {2'b11, e}) begin
                    miscompares++;
                    $display("FAIL w1 bit c=%0d: got %b want %b", c,
                             {d1_dout_valid, d1_ready, d1_dout, d1_dout_last}, {2'b11, e});
                end
            end else if ({d1_dout_valid, d1_dout, d1_dout_last} !== 3'b000) begin
                miscompares++;
                $display("FAIL w1 idle: got %b want 000", {d1_dout_valid, d1_dout, d1_dout_last});
            end
            if (c < 7) begin
                d1_din = pat[c+1]; exp_q.push_back({pat[c+1], 1'b1});
            end else begin
                d1_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single_word(6'b101100, "single");
        test_back_to_back();
        test_loopback();
        test_reset_mid_word();
        test_din_change();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
